// File: rtl/synth_pkg.sv
// Shared sizes, index types and FSM encodings for the synth voice path.
package synth_pkg;

  localparam int NUM_KEYS   = 12;
  localparam int NUM_VOICES = 4;
  localparam int KEY_W      = $clog2(NUM_KEYS);
  localparam int VOICE_W    = $clog2(NUM_VOICES);
  localparam int RANK_W     = VOICE_W;

  typedef logic [KEY_W-1:0]   key_idx_t;
  typedef logic [VOICE_W-1:0] voice_idx_t;
  typedef logic [RANK_W-1:0]  rank_t;

  localparam rank_t RANK_MAX = rank_t'(NUM_VOICES - 1);

  typedef logic [0:0] state_t;
  localparam state_t S_IDLE    = 1'b0;
  localparam state_t S_SERVICE = 1'b1;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module prio_enc #(
  parameter int W = 4
) (
  input  logic [W-1:0]         req,
  output logic [$clog2(W)-1:0] idx,
  output logic                 valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = ($clog2(W))'(i);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: queues key press/release edges and binds keys to
// voices one event per clock, stealing the oldest voice when all are busy.
//
// state     | meaning
// S_IDLE    | no press or release event pending
// S_SERVICE | at least one pending event, one serviced per clock
module voice_allocator
  import synth_pkg::*;
(
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_KEYS-1:0]         gate_in,
  output logic [NUM_VOICES-1:0]       voice_active_out,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key_out,
  output logic [NUM_VOICES-1:0]       voice_trig_out,
  output logic [NUM_VOICES-1:0]       voice_rel_out,
  output logic                        steal_out,
  output logic                        busy_out
);

  logic [NUM_KEYS-1:0]   gate_prev;
  logic [NUM_KEYS-1:0]   rise;
  logic [NUM_KEYS-1:0]   fall;
  logic [NUM_KEYS-1:0]   pend_press;
  logic [NUM_KEYS-1:0]   pend_rel;
  logic [NUM_KEYS-1:0]   pend_press_nxt;
  logic [NUM_KEYS-1:0]   pend_rel_nxt;
  state_t                state_q;
  state_t                state_nxt;

  key_idx_t              key_q    [NUM_VOICES];
  key_idx_t              key_nxt  [NUM_VOICES];
  rank_t                 rank_q   [NUM_VOICES];
  rank_t                 rank_nxt [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_nxt;
  logic [NUM_VOICES-1:0] trig_nxt;
  logic [NUM_VOICES-1:0] rel_nxt;
  logic [NUM_VOICES-1:0] inactive;
  logic                  steal_nxt;

  key_idx_t              rel_idx;
  key_idx_t              press_idx;
  key_idx_t              svc_key;
  logic                  rel_vld;
  logic                  press_vld;
  logic                  free_vld;
  voice_idx_t            free_idx;
  voice_idx_t            hit_idx;
  voice_idx_t            victim_idx;
  voice_idx_t            bind_idx;
  rank_t                 victim_rank;
  logic                  hit_vld;
  logic                  svc_en;
  logic                  do_rel;
  logic                  do_press;
  logic                  do_bind;

  assign rise     = gate_in & ~gate_prev;
  assign fall     = ~gate_in & gate_prev;
  assign inactive = ~voice_active_out;

  prio_enc #(.W(NUM_KEYS)) u_rel_enc (
    .req   (pend_rel),
    .idx   (rel_idx),
    .valid (rel_vld)
  );

  prio_enc #(.W(NUM_KEYS)) u_press_enc (
    .req   (pend_press),
    .idx   (press_idx),
    .valid (press_vld)
  );

  prio_enc #(.W(NUM_VOICES)) u_free_enc (
    .req   (inactive),
    .idx   (free_idx),
    .valid (free_vld)
  );

  // Releases always drain ahead of presses.
  assign svc_en   = (state_q == S_SERVICE);
  assign do_rel   = svc_en && rel_vld;
  assign do_press = svc_en && !rel_vld && press_vld;
  assign svc_key  = rel_vld ? rel_idx : press_idx;

  always_comb begin
    hit_vld     = 1'b0;
    hit_idx     = '0;
    victim_idx  = '0;
    victim_rank = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voice_active_out[v] && (key_q[v] == svc_key)) begin
        hit_vld = 1'b1;
        hit_idx = voice_idx_t'(v);
      end
      // Downward scan with >= leaves the lowest index among equal ranks.
      if (voice_active_out[v] && (rank_q[v] >= victim_rank)) begin
        victim_idx  = voice_idx_t'(v);
        victim_rank = rank_q[v];
      end
    end
  end

  always_comb begin
    active_nxt = voice_active_out;
    trig_nxt   = '0;
    rel_nxt    = '0;
    steal_nxt  = 1'b0;
    do_bind    = 1'b0;
    bind_idx   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      key_nxt[v]  = key_q[v];
      rank_nxt[v] = rank_q[v];
    end

    if (do_rel && hit_vld) begin
      active_nxt[hit_idx] = 1'b0;
      rel_nxt[hit_idx]    = 1'b1;
    end

    if (do_press) begin
      if (hit_vld) begin
        trig_nxt[hit_idx] = 1'b1;
      end else if (free_vld) begin
        do_bind  = 1'b1;
        bind_idx = free_idx;
      end else begin
        do_bind   = 1'b1;
        bind_idx  = victim_idx;
        steal_nxt = 1'b1;
      end
    end

    if (do_bind) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (bind_idx == voice_idx_t'(v)) begin
          rank_nxt[v] = '0;
        end else if (voice_active_out[v] && (rank_q[v] != RANK_MAX)) begin
          rank_nxt[v] = rank_q[v] + rank_t'(1);
        end
      end
      active_nxt[bind_idx] = 1'b1;
      key_nxt[bind_idx]    = svc_key;
      trig_nxt[bind_idx]   = 1'b1;
    end
  end

  always_comb begin
    pend_press_nxt = pend_press;
    pend_rel_nxt   = pend_rel;
    for (int k = 0; k < NUM_KEYS; k++) begin
      logic svc_p;
      logic svc_r;
      svc_p = do_press && (press_idx == key_idx_t'(k));
      svc_r = do_rel && (rel_idx == key_idx_t'(k));

      if (rise[k])     pend_press_nxt[k] = 1'b1;
      else if (fall[k]) pend_press_nxt[k] = 1'b0;
      else if (svc_p)   pend_press_nxt[k] = 1'b0;

      // A fall that cancels a still-queued press leaves the release mask alone.
      if (fall[k] && !(pend_press[k] && !svc_p)) pend_rel_nxt[k] = 1'b1;
      else if (svc_r)                             pend_rel_nxt[k] = 1'b0;
    end
    state_nxt = ((pend_press_nxt | pend_rel_nxt) != '0) ? S_SERVICE : S_IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      gate_prev        <= '0;
      pend_press       <= '0;
      pend_rel         <= '0;
      state_q          <= S_IDLE;
      voice_active_out <= '0;
      voice_trig_out   <= '0;
      voice_rel_out    <= '0;
      steal_out        <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v]  <= '0;
        rank_q[v] <= '0;
      end
    end else begin
      gate_prev        <= gate_in;
      pend_press       <= pend_press_nxt;
      pend_rel         <= pend_rel_nxt;
      state_q          <= state_nxt;
      voice_active_out <= active_nxt;
      voice_trig_out   <= trig_nxt;
      voice_rel_out    <= rel_nxt;
      steal_out        <= steal_nxt;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v]  <= key_nxt[v];
        rank_q[v] <= rank_nxt[v];
      end
    end
  end

  always_comb begin
    voice_key_out = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key_out[v*KEY_W +: KEY_W] = key_q[v];
    end
  end

  assign busy_out = (state_q == S_SERVICE);

endmodule
